// File: rtl/regfile_read_port_pkg.sv
// Shared constants and FSM state type for the register-file read port.
package regfile_read_port_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NREGS      = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_read_port_mux16_fwd.sv
// Combinational 16:1 register select with same-cycle write-data forward override.
module mux16_fwd
    import regfile_read_port_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [NREGS*WIDTH-1:0] i_regs,
    input  logic [NREGS-1:0]       i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic [REG_ADDR_W-1:0]  i_addr,
    output logic [WIDTH-1:0]       o_value,
    output logic                   o_fwd
);

    logic [WIDTH-1:0] w_reg_val;

    always_comb begin
        w_reg_val = i_regs[i_addr*WIDTH +: WIDTH];
        // Only this address's enable bit matters, even if wr_en is multi-hot.
        o_fwd     = i_wr_en[i_addr];
        o_value   = o_fwd ? i_wr_data : w_reg_val;
    end

endmodule

// File: rtl/regfile_read_port.sv
// Two-operand register-file read port with write forwarding and a one-deep
// valid/ready output register feeding the ALU operand stage.
module regfile_read_port
    import regfile_read_port_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREGS*WIDTH-1:0] regs_in,
    input  logic [NREGS-1:0]       wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [REG_ADDR_W-1:0]  addr_a,
    input  logic [REG_ADDR_W-1:0]  addr_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       data_a,
    output logic [WIDTH-1:0]       data_b,
    output logic                   fwd_a,
    output logic                   fwd_b,
    output logic                   wr_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_multi_hot;
    logic [WIDTH-1:0] w_val_a;
    logic [WIDTH-1:0] w_val_b;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic [WIDTH-1:0] r_data_a;
    logic [WIDTH-1:0] r_data_b;
    logic             r_fwd_a;
    logic             r_fwd_b;
    logic             r_wr_err;

    mux16_fwd #(.WIDTH(WIDTH)) u_mux_a (
        .i_regs    (regs_in),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_addr    (addr_a),
        .o_value   (w_val_a),
        .o_fwd     (w_fwd_a)
    );

    mux16_fwd #(.WIDTH(WIDTH)) u_mux_b (
        .i_regs    (regs_in),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_addr    (addr_b),
        .o_value   (w_val_b),
        .o_fwd     (w_fwd_b)
    );

    // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
    assign w_multi_hot = |(wr_en & (wr_en - 1'b1));

    always_comb begin
        req_ready   = (r_state == EMPTY) | rsp_ready;
        w_accept    = req_valid & req_ready;
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (rsp_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_data_a <= '0;
            r_data_b <= '0;
            r_fwd_a  <= 1'b0;
            r_fwd_b  <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data_a <= w_val_a;
                r_data_b <= w_val_b;
                r_fwd_a  <= w_fwd_a;
                r_fwd_b  <= w_fwd_b;
            end
            if (w_multi_hot) r_wr_err <= 1'b1;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign data_a    = r_data_a;
    assign data_b    = r_data_b;
    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_regfile_read_port.sv
// Randomized and directed bench for regfile_read_port against a behavioural model.
module tb_regfile_read_port;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [16*W-1:0] regs_in;
    logic [15:0]     wr_en;
    logic [W-1:0]    wr_data;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      addr_a;
    logic [3:0]      addr_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    data_a;
    logic [W-1:0]    data_b;
    logic            fwd_a;
    logic            fwd_b;
    logic            wr_err;

    int checks = 0;
    int errors = 0;

    regfile_read_port #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regs_in   (regs_in),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: a one-slot holding buffer plus a sticky error bit.
    logic         m_valid;
    logic [W-1:0] m_a, m_b;
    logic         m_fa, m_fb;
    logic         m_err;

    function automatic logic [W-1:0] pick(input logic [3:0] ad);
        logic [W-1:0] regs [16];
        for (int i = 0; i < 16; i++) regs[i] = regs_in[i*W +: W];
        return wr_en[ad] ? wr_data : regs[ad];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_fa = 1'b0; m_fb = 1'b0; m_err = 1'b0;
        end else begin
            int ones;
            bit take;
            ones = $countones(wr_en);
            take = req_valid && (!m_valid || rsp_ready);
            if (ones > 1) m_err = 1'b1;
            if (take) begin
                m_a  = pick(addr_a);
                m_b  = pick(addr_b);
                m_fa = wr_en[addr_a];
                m_fb = wr_en[addr_b];
                m_valid = 1'b1;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_ready;
        exp_ready = !m_valid || rsp_ready;
        checks++;
        if ({rsp_valid, req_ready, data_a, data_b, fwd_a, fwd_b, wr_err} !==
            {m_valid, exp_ready, m_a, m_b, m_fa, m_fb, m_err}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got v=%b rdy=%b a=%h b=%h fa=%b fb=%b err=%b exp v=%b rdy=%b a=%h b=%h fa=%b fb=%b err=%b",
                     $time, rsp_valid, req_ready, data_a, data_b, fwd_a, fwd_b, wr_err,
                     m_valid, exp_ready, m_a, m_b, m_fa, m_fb, m_err);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic base_regs;
        for (int i = 0; i < 16; i++) regs_in[i*W +: W] = 16'h1000 + W'(i);
    endtask

    task automatic scenario1(input string tag);
        base_regs();
        wr_en = '0; req_valid = 1'b1; rsp_ready = 1'b1; addr_a = 4'd3; addr_b = 4'd12;
        tick();
        req_valid = 1'b0;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data_a"}, 32'(data_a), 32'h1003);
        chk({tag, "_data_b"}, 32'(data_b), 32'h100C);
        chk({tag, "_fwd"}, 32'({fwd_a, fwd_b}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; regs_in = '0; wr_en = '0; wr_data = '0;
        req_valid = 1'b0; rsp_ready = 1'b0; addr_a = '0; addr_b = '0;
        #12;
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_data", 32'({data_a, data_b}), 32'd0);
        chk("reset_err", 32'(wr_err), 32'd0);
        rst_n = 1'b1;
        tick();

        scenario1("basic");

        // Forwarding into port A only, then both ports on the same address.
        req_valid = 1'b1; wr_en = 16'h0008; wr_data = 16'hBEEF;
        tick();
        chk("fwd_data_a", 32'(data_a), 32'hBEEF);
        chk("fwd_fwd_a", 32'(fwd_a), 32'd1);
        chk("fwd_data_b", 32'(data_b), 32'h100C);
        chk("fwd_fwd_b", 32'(fwd_b), 32'd0);
        addr_b = 4'd3;
        tick();
        chk("fwd_same_ab", 32'({data_a, data_b}), 32'hBEEF_BEEF);
        chk("fwd_same_flags", 32'({fwd_a, fwd_b}), 32'd3);
        wr_en = '0;

        // Backpressure: held snapshot despite changing registers and writes.
        rsp_ready = 1'b0; addr_a = 4'd5; addr_b = 4'd6;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            regs_in = {16{$urandom_range(0, 16'hFFFF)}};
            wr_en = 16'h0020; wr_data = 16'h1234;
            tick();
            chk("bp_hold", 32'({data_a, data_b}), 32'hBEEF_BEEF);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
        end
        wr_en = '0; base_regs(); rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(rsp_valid), 32'd1);
        chk("bp_release_data", 32'({data_a, data_b}), 32'h1005_1006);

        // Streaming: one response per cycle, no bubbles.
        for (int k = 0; k < 16; k++) begin
            addr_a = 4'(k); addr_b = 4'(15 - k);
            tick();
            chk("stream_valid", 32'(rsp_valid), 32'd1);
            chk("stream_data", 32'({data_a, data_b}), {16'h1000 + 16'(k), 16'h1000 + 16'(15 - k)});
        end
        req_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(rsp_valid), 32'd0);

        // Randomized traffic with zero or one-hot writes.
        for (int n = 0; n < 400; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            addr_a = 4'($urandom_range(0, 15));
            addr_b = ($urandom_range(0, 4) == 0) ? addr_a : 4'($urandom_range(0, 15));
            wr_en = ($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 15)) : '0;
            wr_data = 16'($urandom);
            for (int i = 0; i < 16; i++) regs_in[i*W +: W] = 16'($urandom);
            tick();
        end
        req_valid = 1'b0; wr_en = '0;

        // Single-hot never flags; multi-hot sets a sticky error.
        wr_en = 16'h0001;
        tick();
        wr_en = '0;
        chk("onehot_no_err", 32'(wr_err), 32'd0);
        wr_en = 16'h0011;
        tick();
        wr_en = '0;
        chk("multihot_err", 32'(wr_err), 32'd1);
        repeat (3) tick();
        chk("multihot_sticky", 32'(wr_err), 32'd1);

        // Asynchronous reset in the middle of a held response.
        base_regs(); req_valid = 1'b1; rsp_ready = 1'b0; addr_a = 4'd7; addr_b = 4'd8;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_data", 32'({data_a, data_b}), 32'd0);
        chk("async_rst_err", 32'(wr_err), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        scenario1("post_rst");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the 16-entry register file; counterpart of the 1-to-16 write-enable decoder.
- Selects two operands (A, B) from the flattened register array using two 4-bit addresses.
- Forwards same-cycle write data when the decoder's one-hot write-enable hits a read address.
- Registers the result behind a valid/ready handshake for the ALU operand stage.

Parameters:
WIDTH, 16, bit width of one register.
NREGS, 16, number of registers; fixed at 16 because addresses are 4 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
regs_in  input  16*WIDTH  flattened register contents; register i occupies bits [i*WIDTH +: WIDTH].
wr_en  input  16  one-hot write enables from the write decoder; all-zero means no write.
wr_data  input  WIDTH  data being written this cycle.
req_valid  input  1  read request present.
req_ready  output  1  read request accepted this cycle.
addr_a  input  4  operand A register index.
addr_b  input  4  operand B register index.
rsp_valid  output  1  operand pair available.
rsp_ready  input  1  consumer accepts the operand pair.
data_a  output  WIDTH  operand A.
data_b  output  WIDTH  operand B.
fwd_a  output  1  operand A came from forwarded wr_data.
fwd_b  output  1  operand B came from forwarded wr_data.
wr_err  output  1  sticky flag: wr_en was seen with more than one bit set.

Behaviour:
- One clock domain (clk) with asynchronous active-low reset (rst_n).
- Reset values: rsp_valid=0, data_a=0, data_b=0, fwd_a=0, fwd_b=0, wr_err=0.
- Reset applies immediately, mid-transaction included; any held response is dropped.
- Two-state FSM:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - req_ready = (state==EMPTY) | rsp_ready. It is combinational; there is no path from req_valid to req_ready.
- Accept: a request is accepted when req_valid & req_ready.
  - On the accept edge, data_a/data_b/fwd_a/fwd_b load and the state becomes FULL.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Transitions:
  - EMPTY with accept -> FULL.
  - FULL with rsp_ready and no accept -> EMPTY.
  - FULL with rsp_ready and accept -> FULL, loading new data. Back-to-back, one pair per cycle.
  - FULL with no rsp_ready -> FULL. Outputs are held stable and req_ready=0.
- Operand select for port A (port B identical using addr_b):
  - If wr_en[addr_a]==1: data_a <= wr_data and fwd_a <= 1.
  - Otherwise: data_a <= regs_in[addr_a*WIDTH +: WIDTH] and fwd_a <= 0.
- addr_a==addr_b is legal; both ports return the same value and the same fwd flag.
- Forwarding uses only the cycle of accept. Writes that occur while FULL do not update held outputs; the held data is a snapshot.
- wr_err:
  - Sets on any clk edge where popcount(wr_en) > 1, regardless of handshake state.
  - Cleared only by reset.
  - While wr_en is multi-hot, forwarding still uses wr_en[addr] alone.
- No arithmetic is performed; data is passed through bit-exact.

Decomposition:
- Shared package:
  - REG_ADDR_W = 4 and NREGS = 16.
  - FSM state encoding: EMPTY=1'b0, FULL=1'b1.
- Sub-module mux16_fwd: purely combinational 16:1 WIDTH-bit select plus forward override. It takes regs_in, wr_en, wr_data and addr, and returns value and fwd.
  - Instantiated twice, once for port A and once for port B.
  - Top level holds the FSM, output registers and wr_err.

Test Plan:
- Reset, then set regs_in so reg i = 16'h1000+i, wr_en=0. Request addr_a=3, addr_b=12 with rsp_ready=1 -> next cycle rsp_valid=1, data_a=16'h1003, data_b=16'h100C, fwd_a=fwd_b=0.
- Forwarding: same request with wr_en=16'h0008, wr_data=16'hBEEF at accept -> data_a=16'hBEEF, fwd_a=1, data_b=16'h100C, fwd_b=0. With addr_a=addr_b=3 -> both 16'hBEEF and both fwd=1.
- Backpressure: rsp_ready=0 after the first response -> req_ready=0, and outputs hold for 5 cycles even with regs_in changed. When rsp_ready rises the same cycle as a new request -> the new pair loads next cycle and rsp_valid stays 1.
- Streaming: req_valid=1 and rsp_ready=1 for 16 cycles with addr_a=k, addr_b=15-k -> 16 consecutive responses with no bubbles, data_a=16'h1000+k.
- Multi-hot: wr_en=16'h0011 for one cycle -> wr_err=1 next cycle and remains 1 afterwards. wr_en=16'h0001 alone never sets wr_err.
- Async reset: assert rst_n=0 mid-FULL between clock edges -> rsp_valid, data_a, data_b and wr_err all go 0 immediately. After release, the first accept behaves as in scenario 1.
